// File: rtl/hybrid_control_tp_gen.sv
// hybrid_control_tp_gen
//   Hybrid switching controller for the resonant converter bridge. Samples of
//   capacitor voltage/current are scaled (stage 1) and projected onto the
//   externally supplied sin/cos(theta -/+ phi) terms (stage 2). The sign of the
//   projection that belongs to the current automaton state decides when to
//   jump to the next state. Jumps are debounced, followed by a holdoff window
//   and a dead-time window, and a watchdog faults the bridge off when no jump
//   has happened for too long.
//
// Ports
//   i_clock    system clock
//   i_RESET    asynchronous active-low reset
//   i_enable   run enable; low forces idle (state 00, counters and fault clear)
//   i_mode     0 = 2-state frequency modulation, 1 = 4-state phase modulation
//   i_vC/i_iC  signed capacitor voltage / current samples
//   i_s_tmf/i_c_tmf  signed sin/cos(theta - phi), Q1.(TRIG_W-2)
//   i_s_tpf/i_c_tpf  signed sin/cos(theta + phi), Q1.(TRIG_W-2)
//   o_MOSFET   bridge gate commands {M3..M0}
//   o_sigma    sigma, two's complement (01 = +1, 00 = 0, 11 = -1)
//   o_state    automaton state
//   o_jump     one-cycle pulse coincident with each state change
//   o_fault    sticky watchdog fault
module hybrid_control_tp_gen #(
  parameter int DATA_W   = 14,
  parameter int TRIG_W   = 16,
  parameter int MU_Z1    = 86,
  parameter int MU_Z2    = 90,
  parameter int MU_VG    = 312000,
  parameter int DEBOUNCE = 2,
  parameter int HOLDOFF  = 20,
  parameter int DEADTIME = 10,
  parameter int WATCHDOG = 1 << 20
) (
  input  logic              i_clock,
  input  logic              i_RESET,
  input  logic              i_enable,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_vC,
  input  logic [DATA_W-1:0] i_iC,
  input  logic [TRIG_W-1:0] i_s_tmf,
  input  logic [TRIG_W-1:0] i_c_tmf,
  input  logic [TRIG_W-1:0] i_s_tpf,
  input  logic [TRIG_W-1:0] i_c_tpf,
  output logic [3:0]        o_MOSFET,
  output logic [1:0]        o_sigma,
  output logic [1:0]        o_state,
  output logic              o_jump,
  output logic              o_fault
);

  localparam int ACC_W  = 32 + TRIG_W + 2;
  localparam int STAGES = 2;
  localparam int HD_MAX = (HOLDOFF > DEADTIME) ? HOLDOFF : DEADTIME;
  localparam int HD_W   = (HD_MAX < 1) ? 1 : $clog2(HD_MAX + 1);
  localparam int DB_W   = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam int WD_W   = $clog2(WATCHDOG + 1);

  localparam logic signed [ACC_W-1:0] K_Z1 = ACC_W'(MU_Z1);
  localparam logic signed [ACC_W-1:0] K_Z2 = ACC_W'(MU_Z2);
  localparam logic signed [ACC_W-1:0] K_VG = ACC_W'(MU_VG);

  function automatic logic signed [ACC_W-1:0] sx_data(input logic [DATA_W-1:0] v);
    return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] sx_trig(input logic [TRIG_W-1:0] v);
    return {{(ACC_W-TRIG_W){v[TRIG_W-1]}}, v};
  endfunction

  // automaton + control registers
  logic [1:0]      st_q, st_nxt;
  logic            jump_q;
  logic [DB_W-1:0] deb_q;
  logic [HD_W-1:0] hold_q, dead_q;
  logic [WD_W-1:0] wd_q;
  logic            fault_q;
  // vld_pipe[0] = enable seen, vld_pipe[STAGES] = stage-2 holds an enabled sample
  logic [STAGES:0] vld_pipe;

  // datapath
  logic signed [ACC_W-1:0] sig_vg, z1_d, z2_d, c_d;
  logic signed [ACC_W-1:0] z1_q, z2_q, c_q;
  logic signed [ACC_W-1:0] stm_q, ctm_q, stp_q, ctp_q;
  logic signed [ACC_W-1:0] proj_tm, s1_d, s2_d, s3_d;
  logic signed [ACC_W-1:0] s1_q, s2_q, s3_q;

  // control decode
  logic cond, masked, cond_ok, jump_now, wd_hit;

  //--------------------------------------------------------------------------
  // Stage 1: scale samples. The sigma offset uses the registered state, so
  // the first two samples after a jump still carry the old sigma; holdoff
  // masks them.
  //--------------------------------------------------------------------------
  always_comb begin
    sig_vg = '0;
    if (st_q == 2'b00)      sig_vg = K_VG;
    else if (st_q == 2'b10) sig_vg = -K_VG;
    z1_d = K_Z1 * sx_data(i_vC) - sig_vg;
    z2_d = K_Z2 * sx_data(i_iC);
    c_d  = K_VG * sx_trig(i_s_tmf);
  end

  // Stage 2: full-width projections; only the sign bits are consumed.
  always_comb begin
    proj_tm = z1_q * stm_q + z2_q * ctm_q;
    s1_d    = proj_tm + c_q;
    s3_d    = proj_tm - c_q;
    s2_d    = z1_q * stp_q + z2_q * ctp_q;
  end

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      z1_q  <= '0;  z2_q  <= '0;  c_q   <= '0;
      stm_q <= '0;  ctm_q <= '0;  stp_q <= '0;  ctp_q <= '0;
      s1_q  <= '0;  s2_q  <= '0;  s3_q  <= '0;
    end else begin
      z1_q  <= z1_d;
      z2_q  <= z2_d;
      c_q   <= c_d;
      // trig terms travel with their sample so stage 2 pairs matching data
      stm_q <= sx_trig(i_s_tmf);
      ctm_q <= sx_trig(i_c_tmf);
      stp_q <= sx_trig(i_s_tpf);
      ctp_q <= sx_trig(i_c_tpf);
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      st_q   <= 2'b00;
      jump_q <= 1'b0;
    end else if (!i_enable) begin
      st_q   <= 2'b00;
      jump_q <= 1'b0;
    end else begin
      st_q   <= st_nxt;
      jump_q <= jump_now;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    case (st_q)
      2'b00:   cond = ~s1_q[ACC_W-1];
      2'b01:   cond = ~s2_q[ACC_W-1];
      2'b10:   cond =  s3_q[ACC_W-1];
      default: cond =  s2_q[ACC_W-1];
    endcase
    masked   = ~vld_pipe[STAGES] | fault_q | (hold_q != '0) | (dead_q != '0);
    cond_ok  = cond & ~masked;
    jump_now = cond_ok & ((deb_q + DB_W'(1)) == DB_W'(DEBOUNCE));
    wd_hit   = (wd_q + WD_W'(1)) == WD_W'(WATCHDOG);
    st_nxt   = st_q;
    if (jump_now) begin
      // mode 0 from an odd (phase-mod) state steps once to land on an even one
      if (i_mode || st_q[0]) st_nxt = st_q + 2'd1;
      else                   st_nxt = st_q + 2'd2;
    end
  end

  //--------------------------------------------------------------------------
  // Debounce, holdoff, dead-time, watchdog
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      deb_q    <= '0;
      hold_q   <= '0;
      dead_q   <= '0;
      wd_q     <= '0;
      fault_q  <= 1'b0;
      vld_pipe <= '0;
    end else if (!i_enable) begin
      deb_q    <= '0;
      hold_q   <= '0;
      dead_q   <= '0;
      wd_q     <= '0;
      fault_q  <= 1'b0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      deb_q    <= (cond_ok && !jump_now) ? deb_q + DB_W'(1) : '0;
      if (jump_now) begin
        hold_q <= HD_W'(HOLDOFF);
        dead_q <= HD_W'(DEADTIME);
      end else begin
        if (!vld_pipe[0])       dead_q <= HD_W'(DEADTIME);  // enable rising
        else if (dead_q != '0) dead_q <= dead_q - HD_W'(1);
        if (hold_q != '0)      hold_q <= hold_q - HD_W'(1);
      end
      // a jump on the expiry cycle wins and restarts the watchdog
      if (jump_now) begin
        wd_q <= '0;
      end else if (!fault_q) begin
        wd_q <= wd_q + WD_W'(1);
        if (wd_hit) fault_q <= 1'b1;
      end
    end
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    o_state = st_q;
    o_jump  = jump_q;
    o_fault = fault_q;
    case (st_q)
      2'b00:   o_sigma = 2'b01;
      2'b10:   o_sigma = 2'b11;
      default: o_sigma = 2'b00;
    endcase
    o_MOSFET = 4'b0000;
    if (vld_pipe[0] && !fault_q && dead_q == '0) begin
      case (st_q)
        2'b00:   o_MOSFET = 4'b1001;
        2'b10:   o_MOSFET = 4'b0110;
        default: o_MOSFET = 4'b0011;
      endcase
    end
  end

endmodule
